// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: merges the LSU load and store buffer channels onto one memory port.
// Round-robin grant with hold-until-accepted lock; in-order responses routed by a source FIFO.
module lsu_mem_arbiter #(
    parameter int XLEN            = 64,
    parameter int BUFF_IDX_LEN    = 3,
    parameter int EXCEPT_CODE_LEN = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,

    input  logic                       ld_req_valid_i,
    output logic                       ld_req_ready_o,
    input  logic                       ld_req_we_i,
    input  logic [XLEN-1:0]            ld_req_addr_i,
    input  logic [7:0]                 ld_req_be_i,
    input  logic [BUFF_IDX_LEN-1:0]    ld_req_tag_i,

    input  logic                       st_req_valid_i,
    output logic                       st_req_ready_o,
    input  logic                       st_req_we_i,
    input  logic [XLEN-1:0]            st_req_addr_i,
    input  logic [7:0]                 st_req_be_i,
    input  logic [XLEN-1:0]            st_req_wdata_i,
    input  logic [BUFF_IDX_LEN-1:0]    st_req_tag_i,

    output logic                       ld_rsp_valid_o,
    input  logic                       ld_rsp_ready_i,
    output logic [XLEN-1:0]            ld_rsp_rdata_o,
    output logic [BUFF_IDX_LEN-1:0]    ld_rsp_tag_o,
    output logic                       ld_rsp_except_raised_o,
    output logic [EXCEPT_CODE_LEN-1:0] ld_rsp_except_code_o,

    output logic                       st_rsp_valid_o,
    input  logic                       st_rsp_ready_i,
    output logic [BUFF_IDX_LEN-1:0]    st_rsp_tag_o,
    output logic                       st_rsp_except_raised_o,
    output logic [EXCEPT_CODE_LEN-1:0] st_rsp_except_code_o,

    output logic                       mem_valid_o,
    input  logic                       mem_ready_i,
    output logic                       mem_we_o,
    output logic [XLEN-1:0]            mem_addr_o,
    output logic [7:0]                 mem_be_o,
    output logic [XLEN-1:0]            mem_wdata_o,
    output logic [BUFF_IDX_LEN-1:0]    mem_tag_o,

    input  logic                       mem_valid_i,
    output logic                       mem_ready_o,
    input  logic [XLEN-1:0]            mem_rdata_i,
    input  logic [BUFF_IDX_LEN-1:0]    mem_tag_i,
    input  logic                       mem_except_raised_i,
    input  logic [EXCEPT_CODE_LEN-1:0] mem_except_code_i
);

    typedef enum logic {
        SRC_LD = 1'b0,
        SRC_ST = 1'b1
    } src_e;

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    src_e                       last_grant_q;
    src_e                       last_grant_d;
    logic                       lock_q;
    logic                       lock_d;
    src_e                       lock_src_q;
    src_e                       lock_src_d;

    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic [CNT_W-1:0]           count_d;

    src_e                       gnt_src;
    logic                       gnt_valid;
    logic                       has_room;
    logic                       req_hs;
    logic                       has_out;
    logic                       head_st;
    logic                       rsp_hs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A locked source keeps the grant until its request is accepted.
    always_comb begin
        gnt_src = SRC_LD;
        if (lock_q) begin
            gnt_src = lock_src_q;
        end else if (ld_req_valid_i && st_req_valid_i) begin
            gnt_src = (last_grant_q == SRC_LD) ? SRC_ST : SRC_LD;
        end else if (st_req_valid_i) begin
            gnt_src = SRC_ST;
        end
        gnt_valid = (gnt_src == SRC_ST) ? st_req_valid_i : ld_req_valid_i;
    end

    assign has_room    = (count_q < CNT_MAX);
    assign mem_valid_o = gnt_valid & has_room;
    assign req_hs      = mem_valid_o & mem_ready_i;

    assign ld_req_ready_o = gnt_valid & (gnt_src == SRC_LD)
                          & mem_ready_i & has_room;
    assign st_req_ready_o = gnt_valid & (gnt_src == SRC_ST)
                          & mem_ready_i & has_room;

    always_comb begin
        mem_we_o    = ld_req_we_i;
        mem_addr_o  = ld_req_addr_i;
        mem_be_o    = ld_req_be_i;
        mem_wdata_o = '0;
        mem_tag_o   = ld_req_tag_i;
        if (gnt_src == SRC_ST) begin
            mem_we_o    = st_req_we_i;
            mem_addr_o  = st_req_addr_i;
            mem_be_o    = st_req_be_i;
            mem_wdata_o = st_req_wdata_i;
            mem_tag_o   = st_req_tag_i;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_src_d   = lock_src_q;
        if (req_hs) begin
            last_grant_d = gnt_src;
            lock_d       = 1'b0;
        end else if (mem_valid_o) begin
            lock_d     = 1'b1;
            lock_src_d = gnt_src;
        end
    end

    // With nothing outstanding, memory beats are accepted and discarded.
    assign has_out = (count_q != '0);
    assign head_st = fifo_q[rd_ptr_q];

    assign ld_rsp_valid_o = mem_valid_i & has_out & ~head_st;
    assign st_rsp_valid_o = mem_valid_i & has_out & head_st;
    assign mem_ready_o    = ~has_out
                          | (head_st ? st_rsp_ready_i : ld_rsp_ready_i);
    assign rsp_hs         = mem_valid_i & has_out & mem_ready_o;

    assign ld_rsp_rdata_o         = mem_rdata_i;
    assign ld_rsp_tag_o           = mem_tag_i;
    assign ld_rsp_except_raised_o = mem_except_raised_i;
    assign ld_rsp_except_code_o   = mem_except_code_i;
    assign st_rsp_tag_o           = mem_tag_i;
    assign st_rsp_except_raised_o = mem_except_raised_i;
    assign st_rsp_except_code_o   = mem_except_code_i;

    always_comb begin
        count_d = count_q;
        if (req_hs && !rsp_hs) begin
            count_d = count_q + CNT_W'(1);
        end else if (rsp_hs && !req_hs) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= SRC_ST;
            lock_q       <= 1'b0;
            lock_src_q   <= SRC_LD;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_src_q   <= lock_src_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fifo_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (req_hs) begin
                fifo_q[wr_ptr_q] <= gnt_src;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (rsp_hs) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

endmodule

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Merges the load-buffer and store-buffer memory channels of the load-store unit into a single memory port. Requests are arbitrated round-robin with a hold-until-accepted lock. Responses return in request order and are routed back to the issuing channel by an internal source-ID FIFO. Sits between `load_store_unit` and the single-ported data memory or bus adapter.

## Interface
- `MAX_OUTSTANDING`, 4: maximum number of accepted requests awaiting a response; must be ≥1.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `ld_req_valid_i` in 1; `ld_req_ready_o` out 1: load request handshake.
- `ld_req_we_i`/`ld_req_addr_i`/`ld_req_be_i`/`ld_req_tag_i` in 1/XLEN/8/BUFF_IDX_LEN: load request fields.
- `st_req_valid_i` in 1; `st_req_ready_o` out 1: store request handshake.
- `st_req_we_i`/`st_req_addr_i`/`st_req_be_i`/`st_req_wdata_i`/`st_req_tag_i` in 1/XLEN/8/XLEN/BUFF_IDX_LEN: store request fields.
- `ld_rsp_valid_o` out 1; `ld_rsp_ready_i` in 1: load response handshake.
- `ld_rsp_rdata_o`/`ld_rsp_tag_o`/`ld_rsp_except_raised_o`/`ld_rsp_except_code_o` out XLEN/BUFF_IDX_LEN/1/except_code_t: load response fields.
- `st_rsp_valid_o` out 1; `st_rsp_ready_i` in 1: store response handshake.
- `st_rsp_tag_o`/`st_rsp_except_raised_o`/`st_rsp_except_code_o` out BUFF_IDX_LEN/1/except_code_t: store response fields.
- `mem_valid_o` out 1; `mem_ready_i` in 1: memory request handshake.
- `mem_we_o`/`mem_addr_o`/`mem_be_o`/`mem_wdata_o`/`mem_tag_o` out 1/XLEN/8/XLEN/BUFF_IDX_LEN: memory request fields.
- `mem_valid_i` in 1; `mem_ready_o` out 1: memory response handshake.
- `mem_rdata_i`/`mem_tag_i`/`mem_except_raised_i`/`mem_except_code_i` in XLEN/BUFF_IDX_LEN/1/except_code_t: memory response fields.

## Operation
- **State:**
  - `last_grant` (LD/ST; reset ST).
  - `lock_q` (1b; reset 0) and `lock_src_q` (reset LD).
  - Source FIFO of MAX_OUTSTANDING one-bit entries (0 = LD, 1 = ST), with rd/wr pointers wrapping modulo MAX_OUTSTANDING and a `count` of $clog2(MAX_OUTSTANDING+1) bits; all reset 0.
- **Grant selection (combinational):**
  - `lock_q` = 1: the source is `lock_src_q`.
  - Otherwise, only one valid: that one.
  - Otherwise, both valid: the one ≠ `last_grant`.
  - Otherwise, none.
- **Request path:**
  - `mem_valid_o` = granted valid & (`count` < MAX_OUTSTANDING).
  - Request fields are muxed from the granted channel; `mem_wdata_o` = 0 when LD is granted.
  - `mem_tag_o` = the granted tag, unchanged.
  - Granted `*_req_ready_o` = `mem_ready_i` & (`count` < MAX_OUTSTANDING); the other channel's ready = 0.
- **Lock:**
  - Set on `mem_valid_o` & !`mem_ready_i`, with `lock_src_q` ← the granted source.
  - Cleared on a request handshake.
  - The granted source must not change while the lock is set.
- **Request handshake** (`mem_valid_o` & `mem_ready_i`): push the source into the FIFO and set `last_grant` ← source.
- **Full FIFO:** when `count` = MAX_OUTSTANDING, `mem_valid_o` = 0 and both request readies = 0, even if a pop occurs in the same cycle. Push is gated by the registered `count` only.
- **Response routing:**
  - With `count` > 0, the FIFO head selects the destination.
  - `ld_rsp_valid_o` = `mem_valid_i` & head==LD; `st_rsp_valid_o` = `mem_valid_i` & head==ST.
  - `mem_ready_o` = the destination's `*_rsp_ready_i`.
  - rdata, tag and except fields are broadcast to both response ports; only the valid differs.
  - A response handshake pops the FIFO.
- **Spurious response** (`mem_valid_i` with `count` = 0): `mem_ready_o` = 1, the beat is dropped, and no response valid is raised.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Reset:**
  - Asynchronous; state returns to reset values immediately.
  - Outstanding responses are forgotten; later memory beats are dropped as spurious.
  - Outputs during and after reset follow the combinational rules with cleared state: `mem_valid_o` = OR of the request valids, response valids = 0, `mem_ready_o` = 1.

## Timing
- Request path is zero-latency: inputs reach `mem_*_o` in the same cycle.
- Response path is zero-latency and combinational from `mem_valid_i`/`*_rsp_ready_i`.
- The memory must not respond in the same cycle its request is accepted. A response to a request is legal from the next cycle onward.
- Back-to-back throughput is one request per cycle while FIFO space exists.
- Both channels continuously valid: grants alternate LD, ST, LD, … (first grant LD after reset).
- Requesters must hold valid and fields stable until ready (no valid drop before acceptance).

## Test plan
- **Single load:** after reset, `ld_req_valid_i`=1, addr 0x1000, be 0xFF, tag 3, `mem_ready_i`=1 → `mem_valid_o`=1, addr 0x1000, tag 3. Next cycle `mem_valid_i`=1, rdata 0xDEAD, tag 3 → `ld_rsp_valid_o`=1, `st_rsp_valid_o`=0, rdata 0xDEAD.
- **Contention:** both valid for 4 cycles with `mem_ready_i`=1 → grants LD, ST, LD, ST.
- **Lock:** store granted with `mem_ready_i`=0 for 3 cycles while a load becomes valid → `mem_addr_o` stays the store address; ST is granted on the ready cycle, then LD.
- **Full:** MAX_OUTSTANDING=4, issue 4 loads with no response → 5th cycle `mem_valid_o`=0 and `ld_req_ready_o`=0. Return one response → `count`=3 and the next request is accepted the following cycle.
- **Ordered routing and backpressure:** issue LD, ST, LD, then return 3 responses → routed LD, ST, LD. Holding `st_rsp_ready_i`=0 on the second response keeps `mem_ready_o`=0 and the FIFO unpopped.
- **Spurious and reset:** `mem_valid_i`=1 with `count`=0 → `mem_ready_o`=1 and no response valid. Assert reset with 2 outstanding → after release `count`=0 and the first contention grants LD.
